round_key_store: RTL and testbench

Round-key store and read port for the AES datapath. It captures subkeys streamed by the key-expansion front end (write strobe, 4-bit index, 128-bit subkey, clear-valid pulse) into a 15-entry array with per-entry valid bits. It serves single-entry read requests from the cipher round engine, stalling any request whose entry is not yet written. It also flags when the full schedule for the active key length is present.

---
 rtl/round_key_store_if.sv | 33 +++
 rtl/round_key_store.sv | 157 +++++++++++++++
 tb/tb_round_key_store.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/round_key_store_if.sv
// Bus bundle between the AES key-expansion front end / round engine and the
// round-key store.
//   master : drives key_len, clr_valid, the write port and read requests
//   slave  : the store; returns rd_ready, the read response, key_ready and
//            last_idx
interface round_key_store_if #(
  parameter int AW = 4,
  parameter int DW = 128
);
  logic [1:0]    key_len;
  logic          clr_valid;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_err;
  logic          key_ready;
  logic [AW-1:0] last_idx;

  modport master (
    output key_len, clr_valid, wr_valid, wr_addr, wr_data, rd_req, rd_addr,
    input  rd_ready, rd_valid, rd_data, rd_err, key_ready, last_idx
  );

  modport slave (
    input  key_len, clr_valid, wr_valid, wr_addr, wr_data, rd_req, rd_addr,
    output rd_ready, rd_valid, rd_data, rd_err, key_ready, last_idx
  );
endinterface

// File: rtl/round_key_store.sv
// Round-key store for the AES datapath.
// Captures subkeys from the key-expansion front end into a DEPTH-entry array
// with per-entry valid bits, serves single-entry reads to the round engine
// (stalling until the requested entry is written) and flags when the whole
// schedule for the active key length is present.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous, active-high
//   bus    : round_key_store_if.slave (write port, clear, read request/response,
//            key_ready, last_idx)
module round_key_store #(
  parameter int DEPTH = 15,
  parameter int AW    = 4,
  parameter int DW    = 128
) (
  input  logic               clk,
  input  logic               reset,
  round_key_store_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int VW = 1 << AW;

  // Index of the final round key for a given key length code.
  function automatic logic [AW-1:0] last_of(input logic [1:0] kl);
    case (kl)
      2'b01:   last_of = AW'(10);
      2'b10:   last_of = AW'(12);
      2'b11:   last_of = AW'(14);
      default: last_of = '0;
    endcase
  endfunction

  logic [DW-1:0]    mem [DEPTH];

  state_t           state_q, state_d;
  logic [AW-1:0]    pend_q, pend_d;
  logic [1:0]       klen_q, klen_d;
  logic [DEPTH-1:0] vbit_q, vbit_d;
  logic             key_ready_q, key_ready_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_err_q, rd_err_d;
  logic [DW-1:0]    rd_data_q;

  logic             wr_ok;
  logic [AW-1:0]    last_q_idx, last_d_idx;
  logic [DEPTH-1:0] covered;
  logic [VW-1:0]    vbit_pad;
  logic [AW-1:0]    sel_addr;
  logic             sel_active, sel_err, sel_hit, sel_fwd;
  logic             go_resp, load_mem, use_fwd;

  // Index DEPTH and above is not backed by storage; such writes are dropped.
  assign wr_ok      = bus.wr_valid && (bus.wr_addr < AW'(DEPTH));
  assign klen_d     = bus.clr_valid ? bus.key_len : klen_q;
  assign last_q_idx = last_of(klen_q);
  assign last_d_idx = last_of(klen_d);

  // Clear applies before a same-cycle write, so the write's bit survives.
  // key_ready looks at the post-update bits and key length.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign vbit_d[gi]  = (vbit_q[gi] && !bus.clr_valid) ||
                           (wr_ok && (bus.wr_addr == AW'(gi)));
      assign covered[gi] = vbit_d[gi] || (AW'(gi) > last_d_idx);
    end
  endgenerate

  assign key_ready_d = (&covered) && (klen_d != 2'b00);

  // Zero-extended so an out-of-range index reads as "not valid".
  assign vbit_pad = VW'(vbit_q);

  // In IDLE the incoming address is evaluated directly; in WAIT the latched
  // one. Error is checked against the current key length every cycle, so a
  // key-length change while waiting can turn the request into an error.
  assign sel_addr   = (state_q == IDLE) ? bus.rd_addr : pend_q;
  assign sel_active = ((state_q == IDLE) && bus.rd_req) || (state_q == WAIT);
  assign sel_err    = (sel_addr > last_q_idx) || (klen_q == 2'b00);
  assign sel_hit    = vbit_pad[sel_addr];
  assign sel_fwd    = wr_ok && (bus.wr_addr == sel_addr);
  assign go_resp    = sel_active && (sel_err || sel_hit || sel_fwd);
  assign load_mem   = go_resp && !sel_err && sel_hit;
  assign use_fwd    = go_resp && !sel_err && !sel_hit && sel_fwd;

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    rd_valid_d = go_resp;
    rd_err_d   = go_resp && sel_err;
    case (state_q)
      IDLE: begin
        if (bus.rd_req) begin
          pend_d  = bus.rd_addr;
          state_d = go_resp ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (go_resp) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Storage array kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (!reset && wr_ok) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      klen_q      <= 2'b00;
      vbit_q      <= '0;
      key_ready_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_err_q    <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      klen_q      <= klen_d;
      vbit_q      <= vbit_d;
      key_ready_q <= key_ready_d;
      rd_valid_q  <= rd_valid_d;
      rd_err_q    <= rd_err_d;
      // Registered read; data is zero in every cycle without a response.
      if (use_fwd) begin
        rd_data_q <= bus.wr_data;
      end else if (load_mem) begin
        rd_data_q <= mem[sel_addr];
      end else begin
        rd_data_q <= '0;
      end
    end
  end

  assign bus.rd_ready  = (state_q == IDLE);
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_err    = rd_err_q;
  assign bus.key_ready = key_ready_q;
  assign bus.last_idx  = last_q_idx;

endmodule

// File: tb/tb_round_key_store.sv
module tb_round_key_store;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  round_key_store_if #(.AW(4), .DW(128)) bus ();

  round_key_store #(.DEPTH(15), .AW(4), .DW(128)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  localparam logic [127:0] ONES = {16{8'h01}};
  localparam logic [127:0] DEADBEEF = 128'hDEAD_0000_0000_0000_0000_0000_0000_BEEF;

  function automatic logic [127:0] pat(input int i);
    return ONES * 128'(i);
  endfunction

  typedef struct {
    string        name;
    logic         rst;
    logic         clr;
    logic [1:0]   kl;
    logic         wv;
    logic [3:0]   wa;
    logic [127:0] wd;
    logic         rq;
    logic [3:0]   ra;
    logic         e_rdy;
    logic         e_vld;
    logic         e_err;
    logic [127:0] e_data;
    logic         e_kr;
    logic [3:0]   e_li;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic rst, input logic clr,
                              input logic [1:0] kl, input logic wv, input logic [3:0] wa,
                              input logic [127:0] wd, input logic rq, input logic [3:0] ra,
                              input logic e_rdy, input logic e_vld, input logic e_err,
                              input logic [127:0] e_data, input logic e_kr,
                              input logic [3:0] e_li);
    vec_t v;
    v.name = name; v.rst = rst; v.clr = clr; v.kl = kl; v.wv = wv; v.wa = wa;
    v.wd = wd; v.rq = rq; v.ra = ra; v.e_rdy = e_rdy; v.e_vld = e_vld;
    v.e_err = e_err; v.e_data = e_data; v.e_kr = e_kr; v.e_li = e_li;
    return v;
  endfunction

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cyc(input logic rst, input logic clr, input logic [1:0] kl,
                     input logic wv, input logic [3:0] wa, input logic [127:0] wd,
                     input logic rq, input logic [3:0] ra);
    reset         = rst;
    bus.clr_valid = clr;
    bus.key_len   = kl;
    bus.wr_valid  = wv;
    bus.wr_addr   = wa;
    bus.wr_data   = wd;
    bus.rd_req    = rq;
    bus.rd_addr   = ra;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 2'b00, 1'b0, 4'd0, '0, 1'b0, 4'd0);
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic rdy, input logic vld, input logic err,
                         input logic [127:0] data, input logic kr, input logic [3:0] li);
    chk({nm, ".rd_ready"},  128'(bus.rd_ready),  128'(rdy));
    chk({nm, ".rd_valid"},  128'(bus.rd_valid),  128'(vld));
    chk({nm, ".rd_err"},    128'(bus.rd_err),    128'(err));
    chk({nm, ".rd_data"},   bus.rd_data,         data);
    chk({nm, ".key_ready"}, 128'(bus.key_ready), 128'(kr));
    chk({nm, ".last_idx"},  128'(bus.last_idx),  128'(li));
    $display("[TB] %s: rdy=%0b vld=%0b err=%0b kr=%0b li=%0d data=%h",
             nm, bus.rd_ready, bus.rd_valid, bus.rd_err, bus.key_ready,
             bus.last_idx, bus.rd_data);
  endtask

  initial begin
    int cnt;

    // ---------------- vector table ----------------
    vecs.push_back(mk("reset", 1, 0, 2'b00, 0, 0, '0, 0, 0,  1, 0, 0, '0, 0, 0));
    vecs.push_back(mk("clr192", 0, 1, 2'b10, 0, 0, '0, 0, 0,  1, 0, 0, '0, 0, 12));
    for (int i = 0; i <= 12; i++) begin
      vecs.push_back(mk($sformatf("wr%0d", i), 0, 0, 2'b00, 1, 4'(i), pat(i), 0, 0,
                        1, 0, 0, '0, (i == 12), 12));
    end
    vecs.push_back(mk("rd13_err", 0, 0, 2'b00, 0, 0, '0, 1, 13,  0, 1, 1, '0, 1, 12));
    vecs.push_back(mk("idle_a", 0, 0, 2'b00, 0, 0, '0, 0, 0,  1, 0, 0, '0, 1, 12));
    vecs.push_back(mk("rd12", 0, 0, 2'b00, 0, 0, '0, 1, 12,  0, 1, 0, pat(12), 1, 12));
    vecs.push_back(mk("idle_b", 0, 0, 2'b00, 0, 0, '0, 0, 0,  1, 0, 0, '0, 1, 12));
    vecs.push_back(mk("clr256_wr0", 0, 1, 2'b11, 1, 0, pat(32), 0, 0,  1, 0, 0, '0, 0, 14));
    vecs.push_back(mk("rd0_hit", 0, 0, 2'b00, 0, 0, '0, 1, 0,  0, 1, 0, pat(32), 0, 14));
    vecs.push_back(mk("idle_c", 0, 0, 2'b00, 0, 0, '0, 0, 0,  1, 0, 0, '0, 0, 14));
    vecs.push_back(mk("rd1_stall", 0, 0, 2'b00, 0, 0, '0, 1, 1,  0, 0, 0, '0, 0, 14));
    vecs.push_back(mk("wait1", 0, 0, 2'b00, 0, 0, '0, 0, 0,  0, 0, 0, '0, 0, 14));
    vecs.push_back(mk("wr1_fwd", 0, 0, 2'b00, 1, 1, pat(33), 0, 0,  0, 1, 0, pat(33), 0, 14));
    vecs.push_back(mk("idle_d", 0, 0, 2'b00, 0, 0, '0, 0, 0,  1, 0, 0, '0, 0, 14));

    foreach (vecs[k]) begin
      cyc(vecs[k].rst, vecs[k].clr, vecs[k].kl, vecs[k].wv, vecs[k].wa, vecs[k].wd,
          vecs[k].rq, vecs[k].ra);
      chk_all(vecs[k].name, vecs[k].e_rdy, vecs[k].e_vld, vecs[k].e_err,
              vecs[k].e_data, vecs[k].e_kr, vecs[k].e_li);
    end

    // ---------------- 128-bit schedule load ----------------
    cyc(1, 0, 2'b00, 0, 0, '0, 0, 0);
    cyc(0, 1, 2'b01, 0, 0, '0, 0, 0);
    chk("load128.last_idx", 128'(bus.last_idx), 128'd10);
    for (int i = 0; i <= 10; i++) begin
      cyc(0, 0, 2'b00, 1, 4'(i), pat(i), 0, 0);
      chk($sformatf("load128.kr_after_wr%0d", i), 128'(bus.key_ready), 128'(i == 10));
    end
    cyc(0, 0, 2'b00, 0, 0, '0, 1, 7);
    chk_all("load128.rd7", 0, 1, 0, pat(7), 1, 10);
    idle();
    chk_all("load128.after_rd7", 1, 0, 0, '0, 1, 10);

    // ---------------- stall, then write three cycles later ----------------
    cyc(0, 1, 2'b11, 0, 0, '0, 0, 0);
    cyc(0, 0, 2'b00, 0, 0, '0, 1, 9);
    chk_all("stall.req9", 0, 0, 0, '0, 0, 14);
    idle();
    chk_all("stall.wait_a", 0, 0, 0, '0, 0, 14);
    idle();
    chk_all("stall.wait_b", 0, 0, 0, '0, 0, 14);
    cyc(0, 0, 2'b00, 1, 9, DEADBEEF, 0, 0);
    chk_all("stall.wr9_resp", 0, 1, 0, DEADBEEF, 0, 14);
    idle();
    chk_all("stall.after", 1, 0, 0, '0, 0, 14);

    // Request and matching write in the same cycle.
    cyc(0, 0, 2'b00, 1, 5, pat(85), 1, 5);
    chk_all("fwd.same_cycle", 0, 1, 0, pat(85), 0, 14);
    idle();
    chk_all("fwd.after", 1, 0, 0, '0, 0, 14);

    // ---------------- reset during WAIT ----------------
    cyc(0, 0, 2'b00, 0, 0, '0, 1, 3);
    chk_all("rstwait.req3", 0, 0, 0, '0, 0, 14);
    cyc(1, 0, 2'b00, 0, 0, '0, 0, 0);
    chk_all("rstwait.reset", 1, 0, 0, '0, 0, 0);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 2'b00, (i == 0), 3, pat(3), 0, 0);
      if (bus.rd_valid) cnt++;
    end
    chk("rstwait.no_resp", 128'(cnt), 128'd0);
    chk("rstwait.rdy", 128'(bus.rd_ready), 128'd1);

    // ---------------- rd_req during RESP ignored ----------------
    cyc(0, 1, 2'b01, 1, 2, pat(2), 0, 0);
    cnt = 0;
    cyc(0, 0, 2'b00, 0, 0, '0, 1, 2);
    if (bus.rd_valid) cnt++;
    chk("busy.first_data", bus.rd_data, pat(2));
    cyc(0, 0, 2'b00, 0, 0, '0, 1, 2);
    if (bus.rd_valid) cnt++;
    for (int i = 0; i < 3; i++) begin
      idle();
      if (bus.rd_valid) cnt++;
    end
    chk("busy.one_pulse", 128'(cnt), 128'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
